// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-way burst arbiter for the shared pipelined main-memory port
module mem_arbiter #(
  parameter int BEATS        = 8,
  parameter int MAX_D_STREAK = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [15:0]                i_addr,
  output logic                       i_gnt,
  output logic                       i_data_valid,
  output logic [$clog2(BEATS)-1:0]   i_beat,
  output logic                       i_done,
  input  logic                       d_rd_req,
  input  logic [15:0]                d_rd_addr,
  input  logic                       d_wr_req,
  input  logic [15:0]                d_wr_addr,
  input  logic [15:0]                d_wr_data,
  output logic [$clog2(BEATS)-1:0]   d_wr_beat,
  output logic                       d_gnt,
  output logic                       d_data_valid,
  output logic [$clog2(BEATS)-1:0]   d_beat,
  output logic                       d_rd_done,
  output logic                       d_wr_done,
  output logic [15:0]                data_out,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [15:0]                mem_addr,
  output logic [15:0]                mem_wdata,
  input  logic                       mem_ready,
  input  logic [15:0]                mem_rdata,
  input  logic                       mem_rvalid,
  output logic                       busy,
  output logic                       err
);

  localparam int BW = $clog2(BEATS);
  localparam int CW = $clog2(BEATS + 1);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN, WR} state_t;

  state_t        state;
  logic          owner_i;
  logic [15:0]   base;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] ret_cnt;
  logic [CW-1:0] wr_cnt;
  logic [SW-1:0] d_streak;

  logic          accept;
  logic          rd_state;
  logic          ret_ok;
  logic [CW-1:0] addr_cnt;
  logic          unused_ok;

  assign unused_ok = ^{i_addr[3:0], d_rd_addr[3:0], d_wr_addr[3:0]};

  assign mem_en   = (state == RD_ISSUE) || (state == WR);
  assign mem_wr   = (state == WR);
  assign busy     = (state != IDLE);
  assign accept   = mem_en & mem_ready;
  assign rd_state = (state == RD_ISSUE) || (state == RD_DRAIN);
  // A return is legal only while some accepted read is still unanswered.
  assign ret_ok   = mem_rvalid & rd_state & (ret_cnt < issue_cnt);
  assign addr_cnt = (state == WR) ? wr_cnt : issue_cnt;
  assign mem_addr = mem_en ? (base + (16'(addr_cnt) << 1)) : 16'h0000;

  assign i_data_valid = ret_ok & owner_i;
  assign d_data_valid = ret_ok & ~owner_i;
  assign i_beat       = i_data_valid ? ret_cnt[BW-1:0] : '0;
  assign d_beat       = d_data_valid ? ret_cnt[BW-1:0] : '0;
  assign i_done       = i_data_valid && (ret_cnt == LAST);
  assign d_rd_done    = d_data_valid && (ret_cnt == LAST);
  assign d_wr_beat    = (state == WR) ? wr_cnt[BW-1:0] : '0;
  assign d_wr_done    = (state == WR) && mem_ready && (wr_cnt == LAST);

  // Data buses are forced low while reset is held so every output reads 0.
  assign data_out  = rst ? mem_rdata : 16'h0000;
  assign mem_wdata = rst ? d_wr_data : 16'h0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_i   <= 1'b0;
      base      <= 16'h0000;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      wr_cnt    <= '0;
      d_streak  <= '0;
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      err       <= 1'b0;
    end else begin
      i_gnt <= 1'b0;
      d_gnt <= 1'b0;
      if (mem_rvalid && !ret_ok) err <= 1'b1;

      case (state)
        IDLE: begin
          issue_cnt <= '0;
          ret_cnt   <= '0;
          wr_cnt    <= '0;
          if (i_req && ((d_streak == STREAK_MAX) || (!d_wr_req && !d_rd_req))) begin
            owner_i  <= 1'b1;
            base     <= {i_addr[15:4], 4'b0000};
            d_streak <= '0;
            i_gnt    <= 1'b1;
            state    <= RD_ISSUE;
          end else if (d_wr_req || d_rd_req) begin
            owner_i  <= 1'b0;
            d_gnt    <= 1'b1;
            d_streak <= i_req ? d_streak + SW'(1) : '0;
            if (d_wr_req) begin
              base  <= {d_wr_addr[15:4], 4'b0000};
              state <= WR;
            end else begin
              base  <= {d_rd_addr[15:4], 4'b0000};
              state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (accept) begin
            issue_cnt <= issue_cnt + CW'(1);
            if (issue_cnt == LAST) state <= RD_DRAIN;
          end
        end
        WR: begin
          if (accept) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_cnt == LAST) state <= IDLE;
          end
        end
        default: ;
      endcase

      // Placed after the case so the final return wins over the issue transition.
      if (ret_ok) begin
        ret_cnt <= ret_cnt + CW'(1);
        if (ret_cnt == LAST) state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_rd_req, d_wr_req;
  logic [15:0] i_addr, d_rd_addr, d_wr_addr, d_wr_data;
  logic        i_gnt, i_data_valid, i_done;
  logic [2:0]  i_beat, d_wr_beat, d_beat;
  logic        d_gnt, d_data_valid, d_rd_done, d_wr_done;
  logic [15:0] data_out, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, mem_ready, mem_rvalid, busy, err;

  logic        pv [LAT];
  logic [15:0] pd [LAT];
  logic        inj_rv;
  int          checks = 0;
  int          failures = 0;

  mem_arbiter #(.BEATS(8), .MAX_D_STREAK(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_data_valid(i_data_valid),
    .i_beat(i_beat), .i_done(i_done),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr),
    .d_wr_data(d_wr_data), .d_wr_beat(d_wr_beat), .d_gnt(d_gnt), .d_data_valid(d_data_valid),
    .d_beat(d_beat), .d_rd_done(d_rd_done), .d_wr_done(d_wr_done), .data_out(data_out),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = 16'h0000;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
  endtask

  // Advance one cycle; the memory model returns read data LAT cycles after acceptance.
  task automatic tick();
    logic        f;
    logic [15:0] a;
    f = mem_en && mem_ready && !mem_wr;
    a = mem_addr;
    @(negedge clk);
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = f;
    pd[0] = a ^ 16'hA5A5;
    mem_rvalid = pv[LAT-1] | inj_rv;
    mem_rdata  = pd[LAT-1];
    #1;
    d_wr_data = {13'h1800, d_wr_beat};
    #1;
  endtask

  task automatic run_rd(input bit is_i, input logic [15:0] base, input int stall_beat, input string tag);
    int na = 0;
    int nr = 0;
    int st = 0;
    bit done = 0;
    logic vld, oth, dn;
    logic [2:0] bt;
    for (int c = 0; c < 80 && !done; c++) begin
      mem_ready = !(stall_beat >= 0 && na == stall_beat && st < 2 && mem_en);
      if (!mem_ready) st++;
      #1;
      if (mem_en && mem_ready) begin
        chk({tag, "_addr"}, mem_addr, base + 2 * na);
        na++;
      end else if (mem_en) begin
        chk({tag, "_hold"}, mem_addr, base + 2 * na);
      end
      vld = is_i ? i_data_valid : d_data_valid;
      oth = is_i ? d_data_valid : i_data_valid;
      bt  = is_i ? i_beat : d_beat;
      dn  = is_i ? i_done : d_rd_done;
      if (vld || oth) chk({tag, "_other_valid"}, oth, 0);
      if (vld) begin
        chk({tag, "_beat"}, bt, nr);
        chk({tag, "_data"}, data_out, (base + 2 * nr) ^ 16'hA5A5);
        if (nr == 7) begin
          chk({tag, "_done"}, dn, 1);
          done = 1;
          if (is_i) i_req = 0; else d_rd_req = 0;
        end
        nr++;
      end
      tick();
    end
    mem_ready = 1;
    chk({tag, "_issued"}, na, 8);
    chk({tag, "_returned"}, nr, 8);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic run_wr(input logic [15:0] base);
    int n = 0;
    bit done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_ready = 1;
      #1;
      if (mem_en) begin
        chk("wr_is_write", mem_wr, 1);
        chk("wr_addr", mem_addr, base + 2 * n);
        chk("wr_beat", d_wr_beat, n);
        chk("wr_wdata", mem_wdata, 16'hC000 + n);
        if (d_wr_done) begin
          chk("wr_done_beat", n, 7);
          done = 1;
          d_wr_req = 0;
        end
        n++;
      end
      tick();
    end
    chk("wr_done_seen", done, 1);
    chk("wr_beats", n, 8);
  endtask

  initial begin
    rst = 0; i_req = 0; d_rd_req = 0; d_wr_req = 0; inj_rv = 0;
    i_addr = 0; d_rd_addr = 0; d_wr_addr = 0; d_wr_data = 0; mem_ready = 1;
    clear_pipe();
    @(negedge clk); #1;
    chk("reset_ctrl", {i_gnt, i_data_valid, i_beat, i_done, d_wr_beat, d_gnt, d_data_valid,
                       d_beat, d_rd_done, d_wr_done, mem_en, mem_wr, busy, err}, 0);
    chk("reset_addr", mem_addr, 0);
    rst = 1;
    tick();

    // I fill, latency 3
    i_req = 1; i_addr = 16'h1236;
    tick();
    chk("i_gnt", i_gnt, 1);
    chk("i_gnt_not_d", d_gnt, 0);
    run_rd(1, 16'h1230, -1, "ifill");

    // Writeback beats read; one IDLE cycle between them
    d_wr_req = 1; d_wr_addr = 16'h4010; d_rd_req = 1; d_rd_addr = 16'h8020;
    tick();
    chk("wr_gnt", d_gnt, 1);
    run_wr(16'h4010);
    chk("idle_gap_busy", busy, 0);
    chk("idle_gap_en", mem_en, 0);
    tick();
    chk("rd_after_wr_gnt", d_gnt, 1);
    run_rd(0, 16'h8020, -1, "dfill");

    // Starvation guard: D, D, then I, then D again (with a stall at beat 3)
    i_req = 1; i_addr = 16'h2000; d_rd_addr = 16'h3000;
    for (int k = 0; k < 2; k++) begin
      d_rd_req = 1;
      tick();
      chk("streak_d_gnt", d_gnt, 1);
      chk("streak_no_i", i_gnt, 0);
      run_rd(0, 16'h3000, -1, "streak_d");
    end
    d_rd_req = 1;
    tick();
    chk("forced_i_gnt", i_gnt, 1);
    chk("forced_i_no_d", d_gnt, 0);
    run_rd(1, 16'h2000, -1, "streak_i");
    i_req = 1;
    tick();
    chk("d_after_i_gnt", d_gnt, 1);
    run_rd(0, 16'h3000, 3, "stall_d");
    i_req = 0;
    tick();

    // Stray return while IDLE
    inj_rv = 1;
    tick();
    inj_rv = 0;
    chk("stray_no_ivalid", i_data_valid, 0);
    chk("stray_no_dvalid", d_data_valid, 0);
    tick();
    chk("err_set", err, 1);
    tick(); tick();
    chk("err_sticky", err, 1);
    rst = 0; #1;
    chk("err_cleared", err, 0);
    rst = 1;
    tick();

    // Reset in the middle of a writeback
    d_wr_req = 1; d_wr_addr = 16'h5000;
    tick();
    chk("wr2_gnt", d_gnt, 1);
    for (int k = 0; k < 4; k++) tick();
    chk("wr2_beat4", d_wr_beat, 4);
    chk("wr2_addr4", mem_addr, 16'h5008);
    rst = 0; #1;
    chk("midrst_ctrl", {i_gnt, i_data_valid, i_beat, i_done, d_wr_beat, d_gnt, d_data_valid,
                        d_beat, d_rd_done, d_wr_done, mem_en, mem_wr, busy, err}, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_wdata", mem_wdata, 0);
    chk("midrst_data", data_out, 0);
    d_wr_req = 0;
    clear_pipe();
    tick();
    rst = 1; i_req = 1; i_addr = 16'h7770;
    tick();
    chk("post_rst_i_gnt", i_gnt, 1);
    run_rd(1, 16'h7770, -1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
